seq_pattern_gen: RTL and testbench
==================================

# seq_pattern_gen

Serial stimulus transmitter for the lab's run-of-equal-bits sequence detectors. It loads a parallel pattern and shifts it out MSB-first on a single serial line `w`, one bit per clock. Alongside the bits it produces `z_exp`, a cycle-accurate model of the detector's `z` output, so a board or bench can compare the two directly. It sits upstream of the detector and drives the detector's `w` input and reset-per-transaction framing.

## Interface
- `LEN`, default 16: pattern length in bits, legal 2..32.
- `RUN`, default 4: number of consecutive equal bits that makes `z_exp` assert, legal 2..8.

- `Clock`, input, 1: single clock. All state changes on its rising edge.
- `Reset`, input, 1: asynchronous, active-high. Forces every register to its reset value immediately.
- `Load`, input, 1: when in IDLE, captures `Pattern` into the shift register.
- `Pattern`, input, LEN: parallel pattern; bit LEN-1 is sent first.
- `Start`, input, 1: when in IDLE, begins a transaction.
- `Hold`, input, 1: when in SEND, pauses transmission.
- `w`, output, 1: serial bit.
- `w_valid`, output, 1: high in cycles where `w` carries a new bit.
- `z_exp`, output, 1: expected detector output.
- `busy`, output, 1: high during SEND and PAUSE.
- `done`, output, 1: one-cycle pulse at the end of a transaction.
- `match_count`, output, 8: number of cycles `z_exp` was high in the current or last transaction; saturates at 255.

## Operation
- **State machine:** IDLE, SEND, PAUSE, DONE. The reset state is IDLE.
- **IDLE:**
  - `Load`=1 captures `Pattern`.
  - `Start`=1 moves to SEND, clears the bit counter, the run counter and `match_count`.
  - If `Load` and `Start` are both 1 in the same cycle, the new `Pattern` is loaded and is the one sent.
- **SEND:**
  - `w` = shift register MSB and `w_valid`=1.
  - Each edge shifts left by one and increments the bit counter.
  - After bit LEN, go to DONE.
  - `Hold`=1 at an edge goes to PAUSE instead of shifting.
- **PAUSE:**
  - `w` holds its last value, `w_valid`=0.
  - Bit counter, run counter, `z_exp` and `match_count` are frozen.
  - `Hold`=0 returns to SEND and sends the next unsent bit.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE.
- **Run tracking (registered on each sent bit):**
  - The first bit of a transaction sets run=1.
  - A bit equal to the previous bit gives run=min(run+1, RUN); a different bit gives run=1.
  - `z_exp` = (run == RUN) after the update. This mirrors the detector, which returns to its start state at each transaction.
- `match_count` increments on every cycle `z_exp`=1 during SEND and DONE; it saturates at 255.
- **Ignored inputs:**
  - `Start` and `Load` are ignored outside IDLE.
  - `Hold` is ignored outside SEND.
- **Reset values:** `w`=0, `w_valid`=0, `z_exp`=0, `busy`=0, `done`=0, `match_count`=0, shift register 0, state IDLE.
- Reset during any state aborts the transaction and forces the reset values with no `done` pulse.

## Timing
- Cycle n means the n-th cycle after the edge at which `Start` was sampled in IDLE.
- Bit i (i=1..LEN) is on `w` in cycle i, provided there is no Hold.
- `z_exp` for bit i is visible in cycle i+1: one-cycle latency, the same as the detector's registered state.
- `busy` is high in cycles 1..LEN.
- `done` and the `z_exp` for the last bit are both in cycle LEN+1.
- `z_exp` returns to 0 on entry to IDLE. `match_count` holds its value until the next `Start`.
- Each cycle spent in PAUSE delays every later event by one cycle.
- A new `Start` is accepted no earlier than cycle LEN+2.

## Structure
- **Shared package `seq_pkg`:**
  - state enum (IDLE, SEND, PAUSE, DONE);
  - a width function for the bit counter, clog2(LEN+1);
  - a width function for the run counter, clog2(RUN+1);
  - the constant `MATCH_MAX`=255.
- **Sub-module `run_tracker`:**
  - holds the previous bit, the saturating run counter and the `z_exp` register;
  - inputs: `Clock`, `Reset`, clear (on Start), advance (bit sent), bit.
- The top level holds the FSM, the shift register, the bit counter and `match_count`.

## Test plan
- **Runs of exactly RUN:** LEN=16, RUN=4, `Pattern`=0x0F0F, Load+Start together. Required: `z_exp` high in cycles 5, 9, 13, 17 only; `done` in cycle 17; `match_count`=4.
- **Saturated run:** `Pattern`=0x0000. Required: `z_exp` high in cycles 5..17 (13 cycles); `match_count`=13. Repeat with 0xFFFF for the same result.
- **No runs:** `Pattern`=0xAAAA. Required: `w` alternates 1,0,…; `z_exp` never high; `match_count`=0; `done` in cycle 17.
- **Hold mid-run:** `Pattern`=0x0F0F with `Hold`=1 for 3 cycles after bit 3. Required: `w_valid`=0 in those cycles; the run continues across the pause; `z_exp` first high 3 cycles later than in the first scenario; `done` in cycle 20.
- **Ignored inputs while busy:** `Start` and `Load` (`Pattern`=0xFFFF) asserted in cycle 6 of a 0x0F0F transaction. Required: no effect, the remaining bits are unchanged. A later idle Start sends 0x0F0F again.
- **Reset mid-transaction:** assert `Reset` asynchronously mid-cycle 7. Required: all outputs go to 0 before the next edge, with no `done`. After release, Start with 0x0000 gives `match_count`=13.

Source files
------------

// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and sizing helpers for the serial pattern generator and its run tracker.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } seqState_t;

    localparam int MATCH_MAX = 255;

    function automatic int bitCntWidth(input int len);
        return $clog2(len + 1);
    endfunction

    function automatic int runCntWidth(input int run);
        return $clog2(run + 1);
    endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control and observation bundle between a stimulus source and the pattern generator.
interface seq_pattern_gen_if #(
    parameter int LEN = 16
);

    logic           load;
    logic [LEN-1:0] pattern;
    logic           start;
    logic           hold;
    logic           w;
    logic           w_valid;
    logic           z_exp;
    logic           busy;
    logic           done;
    logic [7:0]     match_count;

    modport master (
        output load, pattern, start, hold,
        input  w, w_valid, z_exp, busy, done, match_count
    );

    modport slave (
        input  load, pattern, start, hold,
        output w, w_valid, z_exp, busy, done, match_count
    );

endinterface

// File: rtl/seq_pattern_gen_run_tracker.sv
// Mirrors the detector: tracks the run of equal bits and registers the expected z.
module run_tracker
    import seq_pkg::*;
#(
    parameter int RUN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic advance_i,
    input  logic bit_i,
    output logic prevBit_o,
    output logic zExp_o
);

    localparam int RW = runCntWidth(RUN);
    localparam logic [RW-1:0] RUN_MAX = RW'(RUN);
    localparam logic [RW-1:0] RUN_ONE = RW'(1);

    logic [RW-1:0] run_q, run_d;
    logic          prevBit_q, prevBit_d;
    logic          zExp_q, zExp_d;

    // A run count of zero marks "no bit seen yet", so the first bit always starts a fresh run.
    always_comb begin
        run_d     = run_q;
        prevBit_d = prevBit_q;
        zExp_d    = zExp_q;
        if (clear_i) begin
            run_d     = '0;
            prevBit_d = 1'b0;
            zExp_d    = 1'b0;
        end else if (advance_i) begin
            prevBit_d = bit_i;
            if (run_q == '0 || bit_i != prevBit_q) begin
                run_d = RUN_ONE;
            end else if (run_q != RUN_MAX) begin
                run_d = run_q + RUN_ONE;
            end
            zExp_d = (run_d == RUN_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q     <= '0;
            prevBit_q <= 1'b0;
            zExp_q    <= 1'b0;
        end else begin
            run_q     <= run_d;
            prevBit_q <= prevBit_d;
            zExp_q    <= zExp_d;
        end
    end

    assign prevBit_o = prevBit_q;
    assign zExp_o    = zExp_q;

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial stimulus transmitter: shifts a loaded pattern out MSB-first and predicts the detector's z.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int LEN = 16,
    parameter int RUN = 4
) (
    input logic         clk,
    input logic         rst,
    seq_pattern_gen_if.slave bus
);

    localparam int CW = bitCntWidth(LEN);
    localparam logic [CW-1:0] LAST_BIT  = CW'(LEN - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [7:0]    MATCH_SAT = 8'(MATCH_MAX);

    seqState_t      state_q, state_d;
    logic [LEN-1:0] shift_q, shift_d;
    logic [CW-1:0]  bitCnt_q, bitCnt_d;
    logic [7:0]     matchCount_q, matchCount_d;

    logic prevBit;
    logic zExp;
    logic trackClear;
    logic trackAdvance;

    // The shift register rotates rather than shifts, so after a full transaction it
    // holds the original pattern again and a bare Start resends it.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bitCnt_d     = bitCnt_q;
        matchCount_d = matchCount_q;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    shift_d = bus.pattern;
                end
                if (bus.start) begin
                    state_d      = SEND;
                    bitCnt_d     = '0;
                    matchCount_d = '0;
                end
            end
            SEND: begin
                shift_d  = {shift_q[LEN-2:0], shift_q[LEN-1]};
                bitCnt_d = bitCnt_q + CNT_ONE;
                if (bitCnt_q == LAST_BIT) begin
                    state_d = DONE;
                end else if (bus.hold) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (!bus.hold) begin
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if ((state_q == SEND || state_q == DONE) && zExp && matchCount_q != MATCH_SAT) begin
            matchCount_d = matchCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bitCnt_q     <= '0;
            matchCount_q <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bitCnt_q     <= bitCnt_d;
            matchCount_q <= matchCount_d;
        end
    end

    // Clearing on the way out of DONE drops z_exp on entry to IDLE.
    assign trackClear   = (state_q == IDLE && bus.start) || (state_q == DONE);
    assign trackAdvance = (state_q == SEND);

    run_tracker #(
        .RUN(RUN)
    ) uTracker (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (trackClear),
        .advance_i (trackAdvance),
        .bit_i     (shift_q[LEN-1]),
        .prevBit_o (prevBit),
        .zExp_o    (zExp)
    );

    assign bus.w           = (state_q == SEND) ? shift_q[LEN-1] : prevBit;
    assign bus.w_valid     = (state_q == SEND);
    assign bus.z_exp       = zExp;
    assign bus.busy        = (state_q == SEND) || (state_q == PAUSE);
    assign bus.done        = (state_q == DONE);
    assign bus.match_count = matchCount_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen (LEN=16, RUN=4) with per-cycle expectation masks.
module tb_seq_pattern_gen;
    import seq_pkg::*;

    localparam int NCYC = 22;

    logic clk;
    logic rst;
    int   vectorCount;
    int   miscompareCount;

    seq_pattern_gen_if #(.LEN(16)) bus ();

    seq_pattern_gen #(
        .LEN(16),
        .RUN(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues Start (optionally with Load) and returns two time units into cycle 1.
    task automatic applyStimulus(input logic [15:0] pat, input logic doLoad);
        bus.pattern = pat;
        bus.load    = doLoad;
        bus.start   = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        bus.load  = 1'b0;
    endtask

    // Masks are indexed by cycle number (bit c = expectation in cycle c).
    task automatic runScenario(
        input string       name,
        input logic [15:0] pat,
        input logic        doLoad,
        input int          holdStart,
        input int          holdLen,
        input int          ignCycle,
        input logic [31:0] expW,
        input logic [31:0] wCare,
        input logic [31:0] expValid,
        input logic [31:0] expBusy,
        input logic [31:0] expZ,
        input int          doneCycle,
        input logic [7:0]  expMatch
    );
        applyStimulus(pat, doLoad);
        for (int c = 1; c <= NCYC; c++) begin
            checkOutput($sformatf("%s c%0d w_valid", name, c), 32'(bus.w_valid), 32'(expValid[c]));
            checkOutput($sformatf("%s c%0d busy", name, c), 32'(bus.busy), 32'(expBusy[c]));
            checkOutput($sformatf("%s c%0d z_exp", name, c), 32'(bus.z_exp), 32'(expZ[c]));
            checkOutput($sformatf("%s c%0d done", name, c), 32'(bus.done), 32'(c == doneCycle));
            if (wCare[c]) begin
                checkOutput($sformatf("%s c%0d w", name, c), 32'(bus.w), 32'(expW[c]));
            end
            bus.hold = (c >= holdStart) && (c < holdStart + holdLen);
            if (c == ignCycle) begin
                bus.start   = 1'b1;
                bus.load    = 1'b1;
                bus.pattern = 16'hFFFF;
            end else begin
                bus.start = 1'b0;
                bus.load  = 1'b0;
            end
            @(posedge clk);
            #2;
        end
        bus.hold = 1'b0;
        checkOutput($sformatf("%s match_count", name), 32'(bus.match_count), 32'(expMatch));
        checkOutput($sformatf("%s idle z_exp", name), 32'(bus.z_exp), 32'd0);
    endtask

    initial begin
        vectorCount     = 0;
        miscompareCount = 0;
        rst         = 1'b1;
        bus.load    = 1'b0;
        bus.start   = 1'b0;
        bus.hold    = 1'b0;
        bus.pattern = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset w", 32'(bus.w), 32'd0);
        checkOutput("reset w_valid", 32'(bus.w_valid), 32'd0);
        checkOutput("reset z_exp", 32'(bus.z_exp), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset match_count", 32'(bus.match_count), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        runScenario("runs4", 16'h0F0F, 1'b1, 0, 0, 0,
                    32'h0001E1E0, 32'h0001FFFE, 32'h0001FFFE, 32'h0001FFFE, 32'h00022220, 17, 8'd4);
        runScenario("zeros", 16'h0000, 1'b1, 0, 0, 0,
                    32'h00000000, 32'h0001FFFE, 32'h0001FFFE, 32'h0001FFFE, 32'h0003FFE0, 17, 8'd13);
        runScenario("ones", 16'hFFFF, 1'b1, 0, 0, 0,
                    32'h0001FFFE, 32'h0001FFFE, 32'h0001FFFE, 32'h0001FFFE, 32'h0003FFE0, 17, 8'd13);
        runScenario("alt", 16'hAAAA, 1'b1, 0, 0, 0,
                    32'h0000AAAA, 32'h0001FFFE, 32'h0001FFFE, 32'h0001FFFE, 32'h00000000, 17, 8'd0);
        runScenario("hold", 16'h0F0F, 1'b1, 3, 3, 0,
                    32'h000F0F00, 32'h000FFFFE, 32'h000FFF8E, 32'h000FFFFE, 32'h00111100, 20, 8'd4);
        runScenario("ignore", 16'h0F0F, 1'b1, 0, 0, 6,
                    32'h0001E1E0, 32'h0001FFFE, 32'h0001FFFE, 32'h0001FFFE, 32'h00022220, 17, 8'd4);
        runScenario("resend", 16'hFFFF, 1'b0, 0, 0, 0,
                    32'h0001E1E0, 32'h0001FFFE, 32'h0001FFFE, 32'h0001FFFE, 32'h00022220, 17, 8'd4);

        // Asynchronous reset in the middle of cycle 7 of a 0x0F0F transaction.
        applyStimulus(16'h0F0F, 1'b1);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("abort w", 32'(bus.w), 32'd0);
        checkOutput("abort w_valid", 32'(bus.w_valid), 32'd0);
        checkOutput("abort z_exp", 32'(bus.z_exp), 32'd0);
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort done", 32'(bus.done), 32'd0);
        checkOutput("abort match_count", 32'(bus.match_count), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #2;
            checkOutput($sformatf("abort hold done %0d", k), 32'(bus.done), 32'd0);
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #2;
            checkOutput($sformatf("post-abort done %0d", k), 32'(bus.done), 32'd0);
            checkOutput($sformatf("post-abort busy %0d", k), 32'(bus.busy), 32'd0);
        end

        runScenario("after-reset", 16'h0000, 1'b1, 0, 0, 0,
                    32'h00000000, 32'h0001FFFE, 32'h0001FFFE, 32'h0001FFFE, 32'h0003FFE0, 17, 8'd13);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
